ternary_conv_stream: RTL and testbench

Streaming, parametrised successor to the combinational ternary-weight convolution in the PicoRV SAM accelerator path. It holds a run-time-loadable kernel of TAPS 2-bit ternary weights {−1, 0, +1} and an internal sliding window of signed samples. It accepts one sample per valid/ready handshake and emits one registered dot product per accepted sample once the window is full. It adds behaviour the combinational block lacks: backpressure, window fill tracking, flush, and optional output saturation instead of silent wrap.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/ternary_tap_sum.sv | 34 +++
 rtl/ternary_conv_stream.sv | 120 ++++++++++++
 tb/tb_ternary_conv_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming ternary convolution.
// Weight code: bit0 = nonzero, bit1 = negate.
package conv_pkg;

    typedef logic [1:0] kw_t;

    localparam kw_t KW_ZERO = 2'b00;
    localparam kw_t KW_POS  = 2'b01;
    localparam kw_t KW_NEG  = 2'b11;

    // Widest accumulator the clamp helper can take; callers sign-extend into it.
    localparam int SAT_MAXW = 128;

    // Clamp a signed value to the signed range of an out_w-bit result.
    function automatic logic signed [SAT_MAXW-1:0] sat_clamp(
        input logic signed [SAT_MAXW-1:0] v,
        input logic        [6:0]          out_w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = '0;
        hi[out_w - 7'd1] = 1'b1;
        hi = hi - SAT_MAXW'(1);
        lo = ~hi;
        if (v > hi) begin
            sat_clamp = hi;
        end else if (v < lo) begin
            sat_clamp = lo;
        end else begin
            sat_clamp = v;
        end
    endfunction

endpackage

// File: rtl/ternary_tap_sum.sv
// Combinational ternary dot product: each sample is added, subtracted or
// skipped according to its 2-bit weight, summed at full accumulator width.
module ternary_tap_sum
    import conv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAPS   = 16,
    parameter int ACC_W  = DATA_W + $clog2(TAPS)
) (
    input  logic        [TAPS-1:0][DATA_W-1:0] i_samples,
    input  kw_t         [TAPS-1:0]             i_weights,
    output logic signed [ACC_W-1:0]            o_sum
);

    logic signed [ACC_W-1:0] w_term [TAPS];

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            logic signed [ACC_W-1:0] w_ext;
            assign w_ext = ACC_W'($signed(i_samples[gi]));
            // Codes 00 and 10 both mean zero, so only the two live codes are matched.
            assign w_term[gi] = (i_weights[gi] == KW_POS) ? w_ext :
                                (i_weights[gi] == KW_NEG) ? -w_ext : '0;
        end
    endgenerate

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            o_sum = o_sum + w_term[i];
        end
    end

endmodule

// File: rtl/ternary_conv_stream.sv
// Streaming ternary convolution: sliding sample window, run-time kernel,
// valid/ready on both sides, flush and optional output saturation.
module ternary_conv_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAPS   = 16,
    parameter int ACC_W  = DATA_W + $clog2(TAPS),
    parameter bit SAT    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       k_wr_en,
    input  logic [$clog2(TAPS)-1:0]    k_wr_addr,
    input  logic [1:0]                 k_wr_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(TAPS+1)-1:0]  fill
);

    localparam int                FILL_W    = $clog2(TAPS+1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TAPS);

    logic [DATA_W-1:0] r_win [TAPS];
    kw_t               r_kernel [TAPS];
    logic [FILL_W-1:0] r_fill;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic [TAPS-1:0][DATA_W-1:0] w_win_next;
    kw_t  [TAPS-1:0]             w_kernel;
    logic                        w_accept;
    logic                        w_complete;
    logic [FILL_W-1:0]           w_fill_next;
    logic signed [ACC_W-1:0]     w_acc;
    logic [DATA_W-1:0]           w_result;

    // The result is taken from the window as it will look after this accept.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_win
            if (gi == 0) begin : g_head
                assign w_win_next[gi] = in_data;
            end else begin : g_body
                assign w_win_next[gi] = r_win[gi-1];
            end
            assign w_kernel[gi] = r_kernel[gi];
        end
    endgenerate

    assign in_ready    = en && !clear && !rst && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_fill_next = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
    assign w_complete  = w_accept && (w_fill_next == FILL_FULL);

    ternary_tap_sum #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ACC_W  (ACC_W)
    ) u_tap_sum (
        .i_samples (w_win_next),
        .i_weights (w_kernel),
        .o_sum     (w_acc)
    );

    generate
        if (SAT) begin : g_sat
            assign w_result = DATA_W'(sat_clamp(SAT_MAXW'(w_acc), 7'(DATA_W)));
        end else begin : g_wrap
            assign w_result = w_acc[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_win[i]    <= '0;
                r_kernel[i] <= KW_ZERO;
            end
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // The tap sum above already saw the old weight this cycle.
            if (k_wr_en) begin
                r_kernel[k_wr_addr] <= k_wr_data;
            end
            if (clear) begin
                for (int i = 0; i < TAPS; i++) begin
                    r_win[i] <= '0;
                end
                r_fill      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_accept) begin
                    for (int i = 0; i < TAPS; i++) begin
                        r_win[i] <= w_win_next[i];
                    end
                    r_fill <= w_fill_next;
                end
                if (w_complete) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_result;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign fill      = r_fill;

endmodule

// File: tb/tb_ternary_conv_stream.sv
// Bench for ternary_conv_stream: a saturating and a wrapping instance share
// stimulus and are compared against a queue-based convolution model.
module tb_ternary_conv_stream;

    localparam int     DATA_W = 32;
    localparam int     TAPS   = 4;
    localparam longint MAXV   = 64'sd2147483647;
    localparam longint MINV   = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst, en, clear, k_wr_en;
    logic [1:0]  k_wr_addr, k_wr_data;
    logic        in_valid, out_ready;
    logic [31:0] in_data;

    logic        s_in_ready, s_out_valid, w_in_ready, w_out_valid;
    logic [31:0] s_out_data, w_out_data;
    logic [2:0]  s_fill, w_fill;

    // Model state: newest sample at hist[0], kernel as plain integers.
    longint      hist[$];
    int          kw[TAPS];
    bit          exp_valid;
    logic [31:0] exp_sat, exp_wrap;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ternary_conv_stream #(.DATA_W(DATA_W), .TAPS(TAPS), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .fill(s_fill)
    );

    ternary_conv_stream #(.DATA_W(DATA_W), .TAPS(TAPS), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .fill(w_fill)
    );

    function automatic bit model_ready();
        return en && !clear && !rst && (!exp_valid || out_ready);
    endfunction

    function automatic int decode_w(input logic [1:0] c);
        if (!c[0]) return 0;
        return c[1] ? -1 : 1;
    endfunction

    task automatic model_reset();
        hist.delete();
        foreach (kw[i]) kw[i] = 0;
        exp_valid = 1'b0;
        exp_sat   = '0;
        exp_wrap  = '0;
    endtask

    // Advance one clock and apply the behavioural rules to the model.
    task automatic tick();
        bit     acc;
        longint s;
        acc = in_valid && model_ready();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (clear) begin
                hist.delete();
                exp_valid = 1'b0;
            end else begin
                if (acc) begin
                    hist.push_front(longint'($signed(in_data)));
                    if (hist.size() > TAPS) void'(hist.pop_back());
                end
                if (acc && hist.size() == TAPS) begin
                    s = 0;
                    for (int i = 0; i < TAPS; i++) s += kw[i] * hist[i];
                    exp_valid = 1'b1;
                    exp_wrap  = s[31:0];
                    exp_sat   = (s > MAXV) ? 32'h7FFFFFFF : ((s < MINV) ? 32'h80000000 : s[31:0]);
                end else if (out_ready) begin
                    exp_valid = 1'b0;
                end
            end
            if (k_wr_en) kw[k_wr_addr] = decode_w(k_wr_data);
        end
        #1;
    endtask

    task automatic send(input logic [31:0] x);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
        $display("[TB] send x=%h fill=%0d out_valid=%0b sat=%h wrap=%h",
                 x, s_fill, s_out_valid, s_out_data, w_out_data);
    endtask

    task automatic load_kernel(input logic [7:0] codes);
        for (int i = 0; i < TAPS; i++) begin
            k_wr_en   = 1'b1;
            k_wr_addr = 2'(i);
            k_wr_data = codes[2*i +: 2];
            tick();
        end
        k_wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        tick(); tick();
        n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", s_in_ready); end
        n_tests++; if (s_out_valid !== 1'b0 || w_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b/%b want 0", s_out_valid, w_out_valid); end
        n_tests++; if (s_out_data !== 32'h0 || w_out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h/%h want 0", s_out_data, w_out_data); end
        n_tests++; if (s_fill !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d want 0", s_fill); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", s_in_ready); end
    endtask

    task automatic test_fill();
        load_kernel(8'b01_01_01_01);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            send(32'(k));
            n_tests++; if (s_fill !== 3'((k < 4) ? k : 4)) begin n_fail++; $display("FAIL fill_%0d: got %0d want %0d", k, s_fill, (k < 4) ? k : 4); end
            n_tests++; if (s_out_valid !== (k >= 4)) begin n_fail++; $display("FAIL fill_valid_%0d: got %b want %b", k, s_out_valid, k >= 4); end
            if (k >= 4) begin
                n_tests++; if (s_out_data !== ((k == 4) ? 32'd10 : 32'd14)) begin n_fail++; $display("FAIL fill_data_%0d: got %0d want %0d", k, s_out_data, (k == 4) ? 10 : 14); end
            end
        end
        tick();
        n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drain: got %b want 0", s_out_valid); end
    endtask

    task automatic test_mixed_kernel();
        do_clear();
        load_kernel(8'b00_10_11_01);
        send(32'd10); send(32'd3); send(32'd7);
        n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL mixed_early: got %b want 0", s_out_valid); end
        send(32'd2);
        n_tests++; if (s_out_valid !== 1'b1 || s_out_data !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL mixed_first: got %b/%h want 1/fffffffb", s_out_valid, s_out_data); end
        send(32'd9);
        n_tests++; if (s_out_data !== 32'd7 || w_out_data !== 32'd7) begin n_fail++; $display("FAIL mixed_second: got %h/%h want 7", s_out_data, w_out_data); end
    endtask

    task automatic test_saturation();
        do_clear();
        load_kernel(8'b01_01_01_01);
        for (int i = 0; i < 4; i++) send(32'h7FFFFFFF);
        n_tests++; if (s_out_data !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fffffff", s_out_data); end
        n_tests++; if (w_out_data !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_pos: got %h want fffffffc", w_out_data); end
        do_clear();
        for (int i = 0; i < 4; i++) send(32'h80000000);
        n_tests++; if (s_out_data !== 32'h80000000) begin n_fail++; $display("FAIL sat_neg: got %h want 80000000", s_out_data); end
        n_tests++; if (w_out_data !== 32'h00000000) begin n_fail++; $display("FAIL wrap_neg: got %h want 0", w_out_data); end
    endtask

    task automatic test_backpressure();
        do_clear();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i));
        in_valid = 1'b1; in_data = 32'd5;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d: got %b want 0", c, s_in_ready); end
            n_tests++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd10) begin n_fail++; $display("FAIL bp_hold_%0d: got %b/%0d want 1/10", c, s_out_valid, s_out_data); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", s_in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd14) begin n_fail++; $display("FAIL b2b_data: got %b/%0d want 1/14", s_out_valid, s_out_data); end
        tick();
        n_tests++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", s_out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        send(32'd6);
        n_tests++; if (s_out_valid !== 1'b1 || s_fill !== 3'd4 || s_out_data !== 32'd18) begin n_fail++; $display("FAIL clr_pre: got %b/%0d/%0d want 1/4/18", s_out_valid, s_fill, s_out_data); end
        clear = 1'b1; in_valid = 1'b1; in_data = 32'd99; out_ready = 1'b1;
        #1;
        n_tests++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b want 0", s_in_ready); end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_tests++; if (s_out_valid !== 1'b0 || s_fill !== 3'd0) begin n_fail++; $display("FAIL clr_post: got %b/%0d want 0/0", s_out_valid, s_fill); end
        for (int i = 0; i < 4; i++) send(32'd1);
        n_tests++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd4) begin n_fail++; $display("FAIL clr_kernel_kept: got %b/%0d want 1/4", s_out_valid, s_out_data); end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        send(32'd1); send(32'd2);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'd7;
        tick();
        n_tests++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0 || s_fill !== 3'd0 || s_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: got v=%b d=%h f=%0d r=%b want 0/0/0/0", s_out_valid, s_out_data, s_fill, s_in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        for (int i = 5; i <= 8; i++) send(32'(i));
        n_tests++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h0 || w_out_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_kernel_zero: got %b/%h/%h want 1/0/0", s_out_valid, s_out_data, w_out_data);
        end
    endtask

    task automatic test_random();
        bit hs;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 10) < 7;
            case ($urandom % 8)
                0:       in_data = 32'h7FFFFFFF;
                1:       in_data = 32'h80000000;
                default: in_data = $urandom;
            endcase
            out_ready = ($urandom % 10) < 7;
            en        = ($urandom % 10) < 9;
            clear     = ($urandom % 40) == 0;
            k_wr_en   = ($urandom % 8) == 0;
            k_wr_addr = 2'($urandom);
            k_wr_data = 2'($urandom);
            #1;
            n_tests++; if (s_in_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready_%0d: got %b want %b", c, s_in_ready, model_ready()); end
            hs = s_out_valid && out_ready;
            tick();
            if (hs) $display("[TB] rnd %0d output taken, next sat=%h wrap=%h", c, s_out_data, w_out_data);
            n_tests++; if (s_out_valid !== exp_valid || w_out_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid_%0d: got %b/%b want %b", c, s_out_valid, w_out_valid, exp_valid); end
            n_tests++; if (s_fill !== 3'(hist.size())) begin n_fail++; $display("FAIL rnd_fill_%0d: got %0d want %0d", c, s_fill, hist.size()); end
            n_tests++; if (s_out_data !== exp_sat) begin n_fail++; $display("FAIL rnd_sat_%0d: got %h want %h", c, s_out_data, exp_sat); end
            n_tests++; if (w_out_data !== exp_wrap) begin n_fail++; $display("FAIL rnd_wrap_%0d: got %h want %h", c, w_out_data, exp_wrap); end
        end
        in_valid = 1'b0; clear = 1'b0; k_wr_en = 1'b0; en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; k_wr_en = 1'b0;
        k_wr_addr = '0; k_wr_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        model_reset();
        test_reset();
        test_fill();
        test_mixed_kernel();
        test_saturation();
        test_backpressure();
        test_clear();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
